dot_stream_acc: RTL and testbench

DOT_STREAM_ACC -- requirements
Module: dot_stream_acc

---
 rtl/dot_stream_acc_if.sv | 29 ++
 rtl/dot_stream_acc.sv | 145 ++++++++++++++
 tb/tb_dot_stream_acc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dot_stream_acc_if.sv
// Stream bundle for dot_stream_acc: operand-beat input channel plus result output channel.
// The master modport is the traffic source/sink (bench or upstream logic); slave is the accumulator.
interface dot_stream_acc_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [DATA_W-1:0] a2;
  logic [DATA_W-1:0] b2;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output a1, b1, a2, b2, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );

  modport slave (
    input  a1, b1, a2, b2, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_valid
  );
endinterface

// File: rtl/dot_stream_acc.sv
// Streaming dot-product accumulator: per beat a1*b1 + a2*b2 through a 3-stage pipeline, summed per frame.
// Optional macro DOT_SAT_EN makes the accumulator add saturate instead of wrapping.
module dot_stream_acc #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dot_stream_acc_if.slave  bus
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              accept;

  logic [DATA_W-1:0] op_a [2];
  logic [DATA_W-1:0] op_b [2];
  logic [ACC_W-1:0]  prod_d [2];
  logic [ACC_W-1:0]  prod_q [2];

  logic              s1_valid_q;
  logic              s1_last_q;
  logic              s2_valid_q;
  logic              s2_last_q;
  logic [ACC_W-1:0]  sum_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]  cnt_q;

  logic [ACC_W-1:0]  out_data_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_valid_q;

  assign accept        = bus.in_valid & in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_valid = out_valid_q;

  assign op_a[0] = bus.a1;
  assign op_b[0] = bus.b1;
  assign op_a[1] = bus.a2;
  assign op_b[1] = bus.b2;

  // Operands are widened/truncated to ACC_W first; the product is then exact modulo 2^ACC_W.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mul
      assign prod_d[gi] = ACC_W'(op_a[gi]) * ACC_W'(op_b[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_q[gi] <= '0;
        end else if (accept) begin
          prod_q[gi] <= prod_d[gi];
        end
      end
    end
  endgenerate

`ifdef DOT_SAT_EN
  logic [ACC_W:0] acc_wide;

  always_comb begin
    acc_wide = {1'b0, acc_q} + {1'b0, sum_q};
    acc_d    = acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_d = acc_q + sum_q;
  end
`endif

  // Beats are counted at accept, so by the time the last beat reaches stage 3 the count already includes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= accept & bus.in_last;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q) begin
        sum_q <= prod_q[0] + prod_q[1];
      end
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        ACCUM: begin
          if (s2_valid_q) begin
            acc_q <= acc_d;
          end
          if (accept && bus.in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (s2_valid_q) begin
            acc_q <= acc_d;
            if (s2_last_q) begin
              out_data_q  <= acc_d;
              out_count_q <= cnt_q;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_stream_acc.sv
// Directed bench for dot_stream_acc: hand-computed frames, exact result timing, HOLD stability, mid-frame reset.
module tb_dot_stream_acc;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  dot_stream_acc_if #(.DATA_W(32), .ACC_W(32), .CNT_W(16)) bus ();

  dot_stream_acc #(.DATA_W(32), .ACC_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drives one beat from a falling edge, holds it across the accepting rising edge, returns on the next falling edge.
  task automatic send_beat(input logic [31:0] a1, input logic [31:0] b1,
                           input logic [31:0] a2, input logic [31:0] b2, input logic last);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("ready_timeout", 64'd0, 64'd1);
    bus.a1 = a1; bus.b1 = b1; bus.a2 = a2; bus.b2 = b2;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;
    bus.a1 = 32'hDEAD_BEEF; bus.b1 = 32'h1234_5678;
    bus.a2 = 32'hCAFE_F00D; bus.b2 = 32'h8765_4321;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.a1 = '0; bus.b1 = '0; bus.a2 = '0; bus.b2 = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Two-beat frame: 1*2+3*4=14, 5*6+7*8=86, total 100; exact result timing
    bus.out_ready = 1'b1;
    send_beat(32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    send_beat(32'd5, 32'd6, 32'd7, 32'd8, 1'b1);
    check("f2_valid_k",   64'(bus.out_valid), 64'd0);
    check("f2_ready_k",   64'(bus.in_ready),  64'd0);
    @(negedge clk);
    check("f2_valid_k1",  64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("f2_valid_k2",  64'(bus.out_valid), 64'd1);
    check("f2_data",      64'(bus.out_data),  64'd100);
    check("f2_count",     64'(bus.out_count), 64'd2);
    @(negedge clk);
    check("f2_valid_k3",  64'(bus.out_valid), 64'd0);
    check("f2_ready_k3",  64'(bus.in_ready),  64'd1);

    // Single beat: 2*3+4*5=26, in_ready low until the output handshake
    bus.out_ready = 1'b0;
    send_beat(32'd2, 32'd3, 32'd4, 32'd5, 1'b1);
    check("f1_ready_k",   64'(bus.in_ready),  64'd0);
    @(negedge clk);
    check("f1_ready_k1",  64'(bus.in_ready),  64'd0);
    @(negedge clk);
    check("f1_valid",     64'(bus.out_valid), 64'd1);
    check("f1_data",      64'(bus.out_data),  64'd26);
    check("f1_count",     64'(bus.out_count), 64'd1);
    check("f1_ready_hold", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("f1_valid_done", 64'(bus.out_valid), 64'd0);
    check("f1_ready_done", 64'(bus.in_ready),  64'd1);

    // Three (1,1,1,1) beats with bubbles -> 6, held for 5 cycles
    for (int i = 0; i < 3; i++) begin
      send_beat(32'd1, 32'd1, 32'd1, 32'd1, (i == 2));
      repeat (2) @(negedge clk);
    end
    wait_valid("f3");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("f3_data_c%0d", i),  64'(bus.out_data),  64'd6);
      check($sformatf("f3_count_c%0d", i), 64'(bus.out_count), 64'd3);
      check($sformatf("f3_valid_c%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("f3_ready_c%0d", i), 64'(bus.in_ready),  64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("f3_valid_done", 64'(bus.out_valid), 64'd0);

    // Next frame starts from zero: 3*3+0*0=9
    send_beat(32'd3, 32'd3, 32'd0, 32'd0, 1'b1);
    wait_valid("f4");
    check("f4_data",  64'(bus.out_data),  64'd9);
    check("f4_count", 64'(bus.out_count), 64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Overflow: four products of 0xFFFE0001 total 0x3_FFF8_0004, which wraps to 0xFFF80004
    send_beat(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b0);
    send_beat(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b1);
    wait_valid("ovf");
`ifdef DOT_SAT_EN
    check("ovf_data", 64'(bus.out_data), 64'hFFFF_FFFF);
`else
    check("ovf_data", 64'(bus.out_data), 64'hFFF8_0004);
`endif
    check("ovf_count", 64'(bus.out_count), 64'd2);
    @(negedge clk);

    // Reset in mid-frame discards the partial frame
    send_beat(32'd9, 32'd9, 32'd9, 32'd9, 1'b0);
    send_beat(32'd7, 32'd7, 32'd7, 32'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_count", 64'(bus.out_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready", 64'(bus.in_ready), 64'd1);
    send_beat(32'd1, 32'd1, 32'd0, 32'd0, 1'b1);
    wait_valid("mrst");
    check("mrst_data",   64'(bus.out_data),  64'd1);
    check("mrst_count1", 64'(bus.out_count), 64'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
